// File: rtl/tpsram_if.sv
// rtl/tpsram_if.sv - write/read/output-enable bundle for the two-port SRAM
interface tpsram_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
);
    logic                   i_wcen;
    logic [BW_ADDR-1:0]     i_waddr;
    logic [BW_DATA-1:0]     i_wdata;
    logic [BW_DATA/8-1:0]   i_wbe;
    logic                   i_rcen;
    logic [BW_ADDR-1:0]     i_raddr;
    logic                   i_oen;
    logic [BW_DATA-1:0]     o_rdata;
    logic                   o_rvalid;
    logic                   o_init_done;

    modport master (
        output i_wcen, i_waddr, i_wdata, i_wbe, i_rcen, i_raddr, i_oen,
        input  o_rdata, o_rvalid, o_init_done
    );

    modport slave (
        input  i_wcen, i_waddr, i_wdata, i_wbe, i_rcen, i_raddr, i_oen,
        output o_rdata, o_rvalid, o_init_done
    );
endinterface

// File: rtl/tpsram.sv
// rtl/tpsram.sv - two-port SRAM with byte enables, self-clearing init and pipelined reads
module tpsram #(
    parameter int BW_DATA    = 32,
    parameter int BW_ADDR    = 5,
    parameter int RD_LATENCY = 1,
    parameter int WR_FIRST   = 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    tpsram_if.slave bus
);
    localparam int DEPTH = 2 ** BW_ADDR;
    localparam int NB    = BW_DATA / 8;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t               state, state_next;
    logic [BW_ADDR-1:0]   cnt, cnt_next;
    logic                 init_done;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 collide;
    logic [BW_DATA-1:0]   wr_old;
    logic [BW_DATA-1:0]   wr_merged;
    logic [BW_DATA-1:0]   rd_word;
    logic [BW_DATA-1:0]   mem [DEPTH];

    logic                 rvalid_s1;
    logic [BW_DATA-1:0]   rdata_s1;
    logic                 rvalid_q;
    logic [BW_DATA-1:0]   rdata_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt parks at DEPTH-1 once the clear sweep finishes
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_INIT: begin
                if (cnt == {BW_ADDR{1'b1}})
                    state_next = S_READY;
                else
                    cnt_next = cnt + BW_ADDR'(1);
            end
            S_READY: ;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        init_done = (state == S_READY);
        wr_accept = init_done && bus.i_wcen && (|bus.i_wbe);
        rd_accept = init_done && bus.i_rcen;
        collide   = wr_accept && (bus.i_waddr == bus.i_raddr);
    end

    always_comb begin
        wr_old    = mem[bus.i_waddr];
        wr_merged = wr_old;
        for (int k = 0; k < NB; k++) begin
            if (bus.i_wbe[k])
                wr_merged[8*k +: 8] = bus.i_wdata[8*k +: 8];
        end
        rd_word = ((WR_FIRST != 0) && collide) ? wr_merged : mem[bus.i_raddr];
    end

    // array has no reset; the INIT sweep is what zeroes it
    always_ff @(posedge i_clk) begin
        if (state == S_INIT)
            mem[cnt] <= '0;
        else if (wr_accept)
            mem[bus.i_waddr] <= wr_merged;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_s1 <= 1'b0;
            rdata_s1  <= '0;
        end else begin
            rvalid_s1 <= rd_accept;
            if (rd_accept)
                rdata_s1 <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic               rvalid_s2;
            logic [BW_DATA-1:0] rdata_s2;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rvalid_s2 <= 1'b0;
                    rdata_s2  <= '0;
                end else begin
                    rvalid_s2 <= rvalid_s1;
                    if (rvalid_s1)
                        rdata_s2 <= rdata_s1;
                end
            end

            assign rvalid_q = rvalid_s2;
            assign rdata_q  = rdata_s2;
        end else begin : g_lat1
            assign rvalid_q = rvalid_s1;
            assign rdata_q  = rdata_s1;
        end
    endgenerate

    assign bus.o_rdata     = bus.i_oen ? rdata_q : '0;
    assign bus.o_rvalid    = rvalid_q;
    assign bus.o_init_done = init_done;
endmodule

// File: tb/tb_tpsram.sv
// tb/tb_tpsram.sv - directed bench for tpsram with cycle-by-cycle reference model
module tb_tpsram;
    parameter int RD_LATENCY = 1;
    parameter int WR_FIRST   = 1;
    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;
    localparam int DEPTH   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpsram_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus();

    tpsram #(
        .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR),
        .RD_LATENCY(RD_LATENCY), .WR_FIRST(WR_FIRST)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    int          gcnt = 0;
    int          edges = 0;
    logic [31:0] ref_mem [DEPTH];
    rd_t         pend [$];
    logic [31:0] last_data = '0;
    bit          started = 0;
    int          rv_count = 0;
    int          first_rv = 0;
    int          last_rv = 0;

    // Reference: edges counts clock edges since reset release; first DEPTH edges are the clear
    always @(posedge clk) begin
        logic [31:0] nw;
        rd_t         e;
        gcnt++;
        if (!rst) begin
            if (edges < DEPTH) begin
                edges++;
                if (edges == DEPTH)
                    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
            end else begin
                nw = merge(ref_mem[bus.i_waddr], bus.i_wdata, bus.i_wbe);
                if (bus.i_rcen) begin
                    e.due  = gcnt + RD_LATENCY - 1;
                    e.data = (WR_FIRST != 0 && bus.i_wcen && bus.i_waddr == bus.i_raddr)
                             ? nw : ref_mem[bus.i_raddr];
                    pend.push_back(e);
                end
                if (bus.i_wcen)
                    ref_mem[bus.i_waddr] = nw;
            end
        end
    end

    always @(negedge clk) begin
        logic        exp_v;
        logic        exp_init;
        if (rst) begin
            pend.delete();
            edges     = 0;
            last_data = '0;
            exp_v     = 1'b0;
        end else begin
            exp_v = (pend.size() > 0) && (pend[0].due == gcnt);
            if (exp_v) begin
                last_data = pend[0].data;
                void'(pend.pop_front());
            end
        end
        exp_init = !rst && (edges >= DEPTH);
        if (started) begin
            chk($sformatf("rvalid@%0d", gcnt), {31'd0, bus.o_rvalid}, {31'd0, exp_v});
            chk($sformatf("rdata@%0d", gcnt), bus.o_rdata, bus.i_oen ? last_data : 32'd0);
            chk($sformatf("init_done@%0d", gcnt), {31'd0, bus.o_init_done}, {31'd0, exp_init});
        end
        if (bus.o_rvalid === 1'b1) begin
            rv_count++;
            if (rv_count == 1) first_rv = gcnt;
            last_rv = gcnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.i_wcen  = 1'b1;
        bus.i_waddr = a;
        bus.i_wdata = d;
        bus.i_wbe   = be;
        tick();
        bus.i_wcen  = 1'b0;
    endtask

    task automatic access(input bit do_wr, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic [4:0] ra,
                          input logic [31:0] exp, input string name);
        int n;
        bus.i_wcen  = do_wr;
        bus.i_waddr = wa;
        bus.i_wdata = wd;
        bus.i_wbe   = be;
        bus.i_rcen  = 1'b1;
        bus.i_raddr = ra;
        tick();
        bus.i_wcen = 1'b0;
        bus.i_rcen = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_rvalid !== 1'b1 && n < 8);
        chk({name, "_valid"}, {31'd0, bus.o_rvalid}, 32'd1);
        chk({name, "_latency"}, 32'(n), 32'(RD_LATENCY));
        chk({name, "_data"}, bus.o_rdata, exp);
    endtask

    task automatic init_wait(input string name);
        bus.i_rcen = 1'b1;
        repeat (DEPTH - 1) begin
            bus.i_raddr = 5'($urandom);
            tick();
        end
        chk({name, "_init_at_31"}, {31'd0, bus.o_init_done}, 32'd0);
        tick();
        chk({name, "_init_at_32"}, {31'd0, bus.o_init_done}, 32'd1);
        bus.i_rcen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_wcen  = 1'b0;
        bus.i_waddr = '0;
        bus.i_wdata = '0;
        bus.i_wbe   = '0;
        bus.i_rcen  = 1'b0;
        bus.i_raddr = '0;
        bus.i_oen   = 1'b1;
        tick();
        started = 1;
        repeat (2) tick();
        chk("reset_init_done", {31'd0, bus.o_init_done}, 32'd0);
        chk("reset_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        chk("reset_rdata", bus.o_rdata, 32'd0);

        rst = 1'b0;
        init_wait("first");
        access(0, 0, 0, 0, 5'd7, 32'h0000_0000, "rd7_zero");

        wr(5'd3, 32'hDEAD_BEEF, 4'hF);
        access(0, 0, 0, 0, 5'd3, 32'hDEAD_BEEF, "rd3_full");
        wr(5'd3, 32'h1122_3344, 4'h5);
        access(0, 0, 0, 0, 5'd3, 32'hDE22_BE44, "rd3_bytes");
        wr(5'd3, 32'hFFFF_FFFF, 4'h0);
        access(0, 0, 0, 0, 5'd3, 32'hDE22_BE44, "rd3_be0");

        access(1, 5'd5, 32'hA5A5_A5A5, 4'hF, 5'd5,
               (WR_FIRST != 0) ? 32'hA5A5_A5A5 : 32'h0000_0000, "collide5");
        access(0, 0, 0, 0, 5'd5, 32'hA5A5_A5A5, "rd5_after");
        access(1, 5'd9, 32'hCAFE_F00D, 4'hF, 5'd3, 32'hDE22_BE44, "diff_addr");
        access(0, 0, 0, 0, 5'd9, 32'hCAFE_F00D, "rd9");

        bus.i_oen = 1'b0;
        tick();
        chk("oen_low_rdata", bus.o_rdata, 32'd0);
        bus.i_oen = 1'b1;
        tick();
        chk("oen_high_hold", bus.o_rdata, 32'hCAFE_F00D);

        for (int i = 0; i < DEPTH; i++) wr(5'(i), 32'(i), 4'hF);
        rv_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.i_rcen  = 1'b1;
            bus.i_raddr = 5'(i);
            bus.i_oen   = i[0];
            tick();
        end
        bus.i_rcen = 1'b0;
        repeat (4) tick();
        bus.i_oen = 1'b1;
        chk("burst_count", 32'(rv_count), 32'd32);
        chk("burst_span", 32'(last_rv - first_rv), 32'd31);

        bus.i_rcen  = 1'b1;
        bus.i_raddr = 5'd9;
        tick();
        bus.i_rcen = 1'b0;
        rst = 1'b1;
        rv_count = 0;
        repeat (3) tick();
        chk("inflight_dropped", 32'(rv_count), 32'd0);

        rst = 1'b0;
        bus.i_rcen = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        rv_count = 0;
        init_wait("restart");
        chk("no_rvalid_in_init", 32'(rv_count), 32'd0);
        access(0, 0, 0, 0, 5'd9, 32'h0000_0000, "rd9_recleared");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
